// File: rtl/fft_input_framer.sv
`timescale 1ns/1ps
// Input framer for the 8-point FFT core: gathers a serial complex sample stream
// into 8-sample frames, then drives the core's write and start pulses.
//
// state | meaning
// IDLE  | waiting for a full fill buffer and an idle core
// LOAD  | frame registers just loaded from the buffer, write pulse high
// FIRE  | start pulse high, busy counter armed with FFT_LATENCY
module fft_input_framer #(
    parameter int DATA_W      = 16,
    parameter int FFT_LATENCY = 4,
    parameter int CHECK_LAST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              in_last,
    output logic              write,
    output logic              start,
    output logic [DATA_W-1:0] frame0_real,
    output logic [DATA_W-1:0] frame1_real,
    output logic [DATA_W-1:0] frame2_real,
    output logic [DATA_W-1:0] frame3_real,
    output logic [DATA_W-1:0] frame4_real,
    output logic [DATA_W-1:0] frame5_real,
    output logic [DATA_W-1:0] frame6_real,
    output logic [DATA_W-1:0] frame7_real,
    output logic [DATA_W-1:0] frame0_imag,
    output logic [DATA_W-1:0] frame1_imag,
    output logic [DATA_W-1:0] frame2_imag,
    output logic [DATA_W-1:0] frame3_imag,
    output logic [DATA_W-1:0] frame4_imag,
    output logic [DATA_W-1:0] frame5_imag,
    output logic [DATA_W-1:0] frame6_imag,
    output logic [DATA_W-1:0] frame7_imag,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIRE = 2'd2
    } state_t;

    localparam logic [3:0] LATENCY = 4'(FFT_LATENCY);

    state_t            state;
    logic [2:0]        fill_idx;
    logic              buf_full;
    logic [3:0]        busy_cnt;
    logic [DATA_W-1:0] buf_real [8];
    logic [DATA_W-1:0] buf_imag [8];
    logic [DATA_W-1:0] frm_real [8];
    logic [DATA_W-1:0] frm_imag [8];

    logic accept;
    logic last_slot;
    logic frame_done;
    logic frame_bad;
    logic transfer;

    assign in_ready  = !buf_full && rst;
    assign accept    = in_valid && in_ready;
    assign last_slot = (fill_idx == 3'd7);
    assign busy      = (busy_cnt != 4'd0);
    assign transfer  = (state == IDLE) && buf_full && (busy_cnt == 4'd0);

    generate
        if (CHECK_LAST != 0) begin : g_check_last
            assign frame_done = accept && last_slot && in_last;
            assign frame_bad  = accept && (last_slot != in_last);
        end else begin : g_count_only
            assign frame_done = accept && last_slot;
            assign frame_bad  = 1'b0;
        end
    endgenerate

    // Fill side: index, full flag and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_idx  <= 3'd0;
            buf_full  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            if (frame_done || frame_bad) begin
                fill_idx <= 3'd0;
            end else if (accept) begin
                fill_idx <= fill_idx + 3'd1;
            end
            if (frame_done) begin
                buf_full <= 1'b1;
            end else if (transfer) begin
                buf_full <= 1'b0;
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_real[fill_idx] <= in_real;
            buf_imag[fill_idx] <= in_imag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            write    <= 1'b0;
            start    <= 1'b0;
            busy_cnt <= 4'd0;
            for (int k = 0; k < 8; k++) begin
                frm_real[k] <= '0;
                frm_imag[k] <= '0;
            end
        end else begin
            if (busy_cnt != 4'd0) begin
                busy_cnt <= busy_cnt - 4'd1;
            end
            case (state)
                IDLE: begin
                    if (transfer) begin
                        for (int k = 0; k < 8; k++) begin
                            frm_real[k] <= buf_real[k];
                            frm_imag[k] <= buf_imag[k];
                        end
                        write <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    write    <= 1'b0;
                    start    <= 1'b1;
                    busy_cnt <= LATENCY;
                    state    <= FIRE;
                end
                FIRE: begin
                    start <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    write <= 1'b0;
                    start <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign frame0_real = frm_real[0];
    assign frame1_real = frm_real[1];
    assign frame2_real = frm_real[2];
    assign frame3_real = frm_real[3];
    assign frame4_real = frm_real[4];
    assign frame5_real = frm_real[5];
    assign frame6_real = frm_real[6];
    assign frame7_real = frm_real[7];
    assign frame0_imag = frm_imag[0];
    assign frame1_imag = frm_imag[1];
    assign frame2_imag = frm_imag[2];
    assign frame3_imag = frm_imag[3];
    assign frame4_imag = frm_imag[4];
    assign frame5_imag = frm_imag[5];
    assign frame6_imag = frm_imag[6];
    assign frame7_imag = frm_imag[7];

endmodule

// File: tb/tb_fft_input_framer.sv
`timescale 1ns/1ps
// Bench for fft_input_framer: directed frames, scoreboard of expected frames
// popped on every write pulse of the main instance.
module tb_fft_input_framer;

    localparam int W = 16;

    typedef struct packed {
        logic [7:0][W-1:0] r;
        logic [7:0][W-1:0] i;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in_real = '0;
    logic [W-1:0] in_imag = '0;
    wire          in_ready, write, start, frame_err, busy;
    wire [7:0][W-1:0] dut_r, dut_i;

    logic         v2 = 1'b0;
    logic [W-1:0] r2 = '0;
    logic [W-1:0] i2 = '0;
    wire          rdy2, wr2, st2, err2, busy2;
    wire [7:0][W-1:0] d2_r, d2_i;

    int     tests = 0;
    int     fails = 0;
    int     wr_cnt = 0;
    int     wr2_cnt = 0;
    frame_t exp_q[$];
    frame_t last_f = '0;

    always #5 clk = ~clk;

    fft_input_framer #(.DATA_W(W), .FFT_LATENCY(4), .CHECK_LAST(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
        .write(write), .start(start),
        .frame0_real(dut_r[0]), .frame1_real(dut_r[1]), .frame2_real(dut_r[2]), .frame3_real(dut_r[3]),
        .frame4_real(dut_r[4]), .frame5_real(dut_r[5]), .frame6_real(dut_r[6]), .frame7_real(dut_r[7]),
        .frame0_imag(dut_i[0]), .frame1_imag(dut_i[1]), .frame2_imag(dut_i[2]), .frame3_imag(dut_i[3]),
        .frame4_imag(dut_i[4]), .frame5_imag(dut_i[5]), .frame6_imag(dut_i[6]), .frame7_imag(dut_i[7]),
        .frame_err(frame_err), .busy(busy)
    );

    // Long core latency and count-only framing, used for the back-pressure case.
    fft_input_framer #(.DATA_W(W), .FFT_LATENCY(15), .CHECK_LAST(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
        .in_real(r2), .in_imag(i2), .in_last(1'b0),
        .write(wr2), .start(st2),
        .frame0_real(d2_r[0]), .frame1_real(d2_r[1]), .frame2_real(d2_r[2]), .frame3_real(d2_r[3]),
        .frame4_real(d2_r[4]), .frame5_real(d2_r[5]), .frame6_real(d2_r[6]), .frame7_real(d2_r[7]),
        .frame0_imag(d2_i[0]), .frame1_imag(d2_i[1]), .frame2_imag(d2_i[2]), .frame3_imag(d2_i[3]),
        .frame4_imag(d2_i[4]), .frame5_imag(d2_i[5]), .frame6_imag(d2_i[6]), .frame7_imag(d2_i[7]),
        .frame_err(err2), .busy(busy2)
    );

    function automatic frame_t mk_frame(input int br, input int sr, input int bi, input int si);
        frame_t f;
        for (int k = 0; k < 8; k++) begin
            f.r[k] = W'(br + k * sr);
            f.i[k] = W'(bi + k * si);
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0][W-1:0] obs_r,
                             input logic [7:0][W-1:0] obs_i, input frame_t e);
        tests++;
        assert ({obs_r, obs_i} === {e.r, e.i}) else begin
            fails++;
            $error("FAIL %s: observed r=%h i=%h expected r=%h i=%h", tag, obs_r, obs_i, e.r, e.i);
        end
    endtask

    // Scoreboard and pulse-ordering monitor for the main instance.
    initial begin
        frame_t ef;
        logic   prev_wr;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_wr = 1'b0;
                last_f  = '0;
            end else begin
                if (write) begin
                    wr_cnt++;
                    chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        ef = exp_q.pop_front();
                        chk_frame("sb_frame", dut_r, dut_i, ef);
                        last_f = ef;
                    end
                    chk("write_idle_core", {30'd0, busy, start}, 32'd0);
                end
                if (start) chk("start_after_write", {31'd0, prev_wr}, 32'd1);
                if (start || busy) chk_frame("frame_stable", dut_r, dut_i, last_f);
                prev_wr = write;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && wr2) wr2_cnt++;
        end
    end

    task automatic send_samples(input frame_t f, input int n, input bit last_final, input bit gaps);
        int w;
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_real  = f.r[k];
            in_imag  = f.i[k];
            in_last  = last_final && (k == n - 1);
            w = 0;
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            if (w >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        if (n == 8 && last_final) exp_q.push_back(f);
    endtask

    task automatic send2(input logic [W-1:0] r, input logic [W-1:0] i);
        int w;
        v2 = 1'b1;
        r2 = r;
        i2 = i;
        w = 0;
        while (!rdy2 && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) chk("ready2_timeout", {31'd0, rdy2}, 32'd1);
        @(posedge clk); #1;
        v2 = 1'b0;
    endtask

    task automatic wait_write(input int target, input int budget);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
        chk("write_count", 32'(wr_cnt), 32'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {27'd0, in_ready, write, start, frame_err, busy}, 32'd0);
        chk_frame({tag, "_frame"}, dut_r, dut_i, '0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        frame_t ramp, fa, fb, fc, fd, g1, g2;
        int n;
        ramp = mk_frame(0, 'h100, 0, 0);
        fa   = mk_frame('h1000, 1, 'hF000, 3);
        fb   = mk_frame('h8001, 'h111, 'h0123, 'h0FED);
        fc   = mk_frame('h7FFF, 0, 'h8000, 0);
        fd   = mk_frame('hA000, 1, 'h5000, 2);
        g1   = mk_frame('h0010, 7, 'h4000, 'h11);
        g2   = mk_frame('hC000, 'h21, 'h0200, 5);

        #1 rst = 1'b0;
        #3;
        chk_all_zero("reset");
        chk("reset2_ready", {31'd0, rdy2}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Basic frame and exact pulse timing.
        send_samples(ramp, 8, 1'b1, 1'b0);
        chk("basic_bubble", {31'd0, in_ready}, 32'd0);
        chk("basic_no_write_yet", {31'd0, write}, 32'd0);
        @(posedge clk); #1;
        chk("basic_write", {30'd0, write, start}, 32'd2);
        chk("basic_ready_back", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("basic_start", {30'd0, write, start}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("basic_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        chk("basic_busy_end", {31'd0, busy}, 32'd0);
        chk_frame("basic_frame", dut_r, dut_i, ramp);
        chk("basic_write_count", 32'(wr_cnt), 32'd1);

        // Two frames back to back.
        send_samples(fa, 8, 1'b1, 1'b0);
        send_samples(fb, 8, 1'b1, 1'b0);
        wait_write(3, 40);
        chk_frame("b2b_frame", dut_r, dut_i, fb);

        // in_last on index 5: discarded.
        send_samples(ramp, 6, 1'b1, 1'b0);
        chk("early_last_err", {31'd0, frame_err}, 32'd1);
        @(posedge clk); #1;
        chk("early_last_err_pulse", {31'd0, frame_err}, 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("early_last_no_write", 32'(wr_cnt), 32'd3);
        chk_frame("early_last_hold", dut_r, dut_i, fb);
        send_samples(fc, 8, 1'b1, 1'b0);
        wait_write(4, 20);
        chk_frame("extreme_frame", dut_r, dut_i, fc);

        // Missing in_last on the 8th sample.
        send_samples(ramp, 8, 1'b0, 1'b0);
        chk("missing_last_err", {31'd0, frame_err}, 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        chk("missing_last_no_write", 32'(wr_cnt), 32'd4);
        chk_frame("missing_last_hold", dut_r, dut_i, fc);

        // Reset mid-fill at index 3.
        send_samples(fd, 3, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("rst_fill");
        exp_q.delete();
        release_reset();
        send_samples(fa, 8, 1'b1, 1'b0);
        wait_write(5, 20);
        chk_frame("after_rst_fill", dut_r, dut_i, fa);
        repeat (8) begin @(posedge clk); #1; end

        // Reset during the LOAD cycle.
        send_samples(fd, 8, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("load_write_high", {31'd0, write}, 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_load");
        exp_q.delete();
        repeat (2) @(posedge clk);
        chk("rst_load_no_start", {31'd0, start}, 32'd0);
        release_reset();

        // Random in_valid gaps inside frames.
        send_samples(ramp, 8, 1'b1, 1'b1);
        wait_write(6, 60);
        chk_frame("gaps_frame", dut_r, dut_i, ramp);
        send_samples(fd, 8, 1'b1, 1'b1);
        wait_write(7, 60);
        chk_frame("gaps_frame2", dut_r, dut_i, fd);

        // Back-pressure on the long-latency instance.
        for (int k = 0; k < 8; k++) send2(g1.r[k], g1.i[k]);
        for (int k = 0; k < 8; k++) send2(g2.r[k], g2.i[k]);
        chk("bp_ready_low", {31'd0, rdy2}, 32'd0);
        chk("bp_busy", {31'd0, busy2}, 32'd1);
        chk("bp_one_write", 32'(wr2_cnt), 32'd1);
        chk_frame("bp_hold_first", d2_r, d2_i, g1);
        n = 0;
        while (!wr2 && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp_wait_cycles", 32'(n), 32'd9);
        chk("bp_busy_at_write", {30'd0, busy2, st2}, 32'd0);
        chk_frame("bp_second", d2_r, d2_i, g2);
        @(posedge clk); #1;
        chk("bp_ready_back", {31'd0, rdy2}, 32'd1);
        chk("bp_no_err", {31'd0, err2}, 32'd0);

        repeat (8) begin @(posedge clk); #1; end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
